// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar datapath.
// Holds field-select codes, BCD calendar constants, the packed date payload
// and BCD step helpers used by the date counter.
package clock_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DAY_W  = 6;
  localparam int unsigned MON_W  = 5;
  localparam int unsigned YR_W   = 8;
  localparam int unsigned BCD8_W = 8;

  // Field select codes
  localparam logic [SEL_W-1:0] SEL_DAY  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MON  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_YR   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'd3;

  // BCD month lengths and month 12
  localparam logic [DAY_W-1:0] BCD_28     = 6'h28;
  localparam logic [DAY_W-1:0] BCD_29     = 6'h29;
  localparam logic [DAY_W-1:0] BCD_30     = 6'h30;
  localparam logic [DAY_W-1:0] BCD_31     = 6'h31;
  localparam logic [MON_W-1:0] BCD_MON_12 = 5'h12;

  // Reset date (year comes from the top-level parameter)
  localparam logic [DAY_W-1:0] RST_DAY = 6'h01;
  localparam logic [MON_W-1:0] RST_MON = 5'h01;
  localparam logic [YR_W-1:0]  YR_MIN  = 8'h00;
  localparam logic [YR_W-1:0]  YR_MAX  = 8'h99;

  // Calendar state payload, all fields BCD
  typedef struct packed {
    logic [DAY_W-1:0] day;
    logic [MON_W-1:0] mon;
    logic [YR_W-1:0]  yr;
  } date_t;

  // Two-digit BCD increment, 99 wraps to 00
  function automatic logic [BCD8_W-1:0] bcd8_inc(input logic [BCD8_W-1:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Two-digit BCD decrement, 00 wraps to 99
  function automatic logic [BCD8_W-1:0] bcd8_dec(input logic [BCD8_W-1:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd0) begin
      o = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      o = o - 4'd1;
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/date_cnt_cal_mdays.sv
// cal_mdays: combinational last-day-of-month lookup in BCD.
// Ports: mon_tens/mon_ones  BCD month
//        yr_tens/yr_ones    BCD two-digit year (2000-2099)
//        last_day_c         BCD last day of that month (28..31)
module cal_mdays
  import clock_pkg::*;
(
  input  logic             mon_tens,
  input  logic [3:0]       mon_ones,
  input  logic [3:0]       yr_tens,
  input  logic [3:0]       yr_ones,
  output logic [DAY_W-1:0] last_day_c
);

  logic leap;
  logic unused_yr_tens_hi;

  // Divisible by 4 depends only on tens parity and the units digit
  assign leap = yr_tens[0] ? ((yr_ones == 4'd2) || (yr_ones == 4'd6))
                           : ((yr_ones == 4'd0) || (yr_ones == 4'd4) || (yr_ones == 4'd8));

  assign unused_yr_tens_hi = ^yr_tens[3:1];

  always_comb begin
    last_day_c = BCD_31;
    case ({mon_tens, mon_ones})
      5'h02:                      last_day_c = leap ? BCD_29 : BCD_28;
      5'h04, 5'h06, 5'h09, 5'h11: last_day_c = BCD_30;
      default:                    last_day_c = BCD_31;
    endcase
  end

endmodule

// File: rtl/date_cnt.sv
// date_cnt: BCD calendar stage (day/month/two-digit year) fed by the
// hours counter's day rollover pulse, with manual incr/dcr set per field.
// Ports: clk, rst (async active-high)
//        day_en     one-cycle day advance pulse
//        incr/dcr   manual step of the field chosen by sel (0 day,1 mon,2 yr,3 none)
//        day_*, mon_*, yr_*  registered BCD date digits
//        cent_en    registered pulse on automatic year 99->00 carry
module date_cnt
  import clock_pkg::*;
#(
  parameter logic [7:0] YR_RST       = 8'h00,
  parameter bit         SATURATE_DCR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             day_en,
  input  logic             incr,
  input  logic             dcr,
  input  logic [SEL_W-1:0] sel,
  output logic [3:0]       day_ones,
  output logic [1:0]       day_tens,
  output logic [3:0]       mon_ones,
  output logic             mon_tens,
  output logic [3:0]       yr_ones,
  output logic [3:0]       yr_tens,
  output logic             cent_en
);

  date_t            cur_q;
  date_t            adv;
  date_t            nxt;
  logic             cent_q;
  logic             cent_c;
  logic [DAY_W-1:0] last_cur;
  logic [DAY_W-1:0] last_new;

  // Month length of the current date (advance and day wrap)
  cal_mdays u_mdays_cur (
    .mon_tens   (cur_q.mon[4]),
    .mon_ones   (cur_q.mon[3:0]),
    .yr_tens    (cur_q.yr[7:4]),
    .yr_ones    (cur_q.yr[3:0]),
    .last_day_c (last_cur)
  );

  // Month length of the candidate date (day clamp)
  cal_mdays u_mdays_new (
    .mon_tens   (adv.mon[4]),
    .mon_ones   (adv.mon[3:0]),
    .yr_tens    (adv.yr[7:4]),
    .yr_ones    (adv.yr[3:0]),
    .last_day_c (last_new)
  );

  // Candidate next date: day_en > incr > dcr
  always_comb begin
    adv    = cur_q;
    cent_c = 1'b0;
    if (day_en) begin
      if (cur_q.day == last_cur) begin
        adv.day = RST_DAY;
        if (cur_q.mon == BCD_MON_12) begin
          adv.mon = RST_MON;
          adv.yr  = bcd8_inc(cur_q.yr);
          cent_c  = (cur_q.yr == YR_MAX);
        end else begin
          adv.mon = MON_W'(bcd8_inc(BCD8_W'(cur_q.mon)));
        end
      end else begin
        adv.day = DAY_W'(bcd8_inc(BCD8_W'(cur_q.day)));
      end
    end else if (incr) begin
      case (sel)
        SEL_DAY: adv.day = (cur_q.day == last_cur) ? RST_DAY
                                                   : DAY_W'(bcd8_inc(BCD8_W'(cur_q.day)));
        SEL_MON: adv.mon = (cur_q.mon == BCD_MON_12) ? RST_MON
                                                     : MON_W'(bcd8_inc(BCD8_W'(cur_q.mon)));
        SEL_YR:  adv.yr  = bcd8_inc(cur_q.yr);
        default: adv     = cur_q;
      endcase
    end else if (dcr) begin
      case (sel)
        SEL_DAY: begin
          if (cur_q.day == RST_DAY) adv.day = SATURATE_DCR ? RST_DAY : last_cur;
          else                      adv.day = DAY_W'(bcd8_dec(BCD8_W'(cur_q.day)));
        end
        SEL_MON: begin
          if (cur_q.mon == RST_MON) adv.mon = SATURATE_DCR ? RST_MON : BCD_MON_12;
          else                      adv.mon = MON_W'(bcd8_dec(BCD8_W'(cur_q.mon)));
        end
        SEL_YR: begin
          if (cur_q.yr == YR_MIN) adv.yr = SATURATE_DCR ? YR_MIN : YR_MAX;
          else                    adv.yr = bcd8_dec(cur_q.yr);
        end
        default: adv = cur_q;
      endcase
    end
  end

  // Clamp day to the new month length; BCD compares correctly as binary
  always_comb begin
    nxt = adv;
    if (adv.day > last_new) nxt.day = last_new;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '{day: RST_DAY, mon: RST_MON, yr: YR_RST};
      cent_q <= 1'b0;
    end else begin
      cur_q  <= nxt;
      cent_q <= cent_c;
    end
  end

  assign day_tens = cur_q.day[5:4];
  assign day_ones = cur_q.day[3:0];
  assign mon_tens = cur_q.mon[4];
  assign mon_ones = cur_q.mon[3:0];
  assign yr_tens  = cur_q.yr[7:4];
  assign yr_ones  = cur_q.yr[3:0];
  assign cent_en  = cent_q;

endmodule
